// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the RV32I memory stage to the byte-addressed data port of mem_ctl.
//   Each request is validated (funct3, optional alignment trap). Legal
//   requests become a single strobed access. The load result is sign- or
//   zero-extended and returned with a one-cycle response pulse and an error
//   code. A stalled access is bounded by a timeout counter.
//
// Optional feature macro:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word accesses
//                          are rejected with code 01 and never issued.
//                          When undefined, every address is issued as-is.
//
// Parameters:
//   TIMEOUT_CYCLES - strobe cycles without mem_ready before a timeout
//                    response (code 11); 0 disables the timeout.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I funct3 of the access
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          request failed
//   resp_err_code     00 none, 01 misaligned, 10 illegal funct3, 11 timeout
//   mem_addr          access address to mem_ctl
//   mem_wdata         right-aligned store data, unused upper bytes zeroed
//   mem_wflag         store funct3
//   mem_we / mem_re   write / read strobes, held until mem_ready
//   mem_rdata         bytes addr+3..addr+0 from mem_ctl
//   mem_ready         access complete
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_wflag,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int          CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic        TO_EN   = (TIMEOUT_CYCLES > 0);

  // Loads accept LB/LH/LW/LBU/LHU, stores accept SB/SH/SW.
  function automatic logic f_funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Right-aligned store data with the bytes beyond the access size cleared.
  function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] v;
    case (size)
      2'b00:   v = {24'h000000, d[7:0]};
      2'b01:   v = {16'h0000, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  // Load extension: funct3[2] selects zero-extension, funct3[1:0] the size.
  function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] v;
    case (f3)
      3'b000:  v = {{24{d[7]}}, d[7:0]};
      3'b001:  v = {{16{d[15]}}, d[15:0]};
      3'b100:  v = {24'h000000, d[7:0]};
      3'b101:  v = {16'h0000, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  state_t         r_state, w_state_nxt;
  logic           r_we, w_we_nxt;
  logic [2:0]     r_funct3, w_funct3_nxt;
  logic [CW-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic           r_req_ready, w_req_ready_nxt;
  logic           r_resp_valid, w_resp_valid_nxt;
  logic [31:0]    r_resp_rdata, w_resp_rdata_nxt;
  logic           r_resp_err, w_resp_err_nxt;
  logic [1:0]     r_resp_err_code, w_resp_err_code_nxt;
  logic [31:0]    r_mem_addr, w_mem_addr_nxt;
  logic [31:0]    r_mem_wdata, w_mem_wdata_nxt;
  logic [2:0]     r_mem_wflag, w_mem_wflag_nxt;
  logic           r_mem_we, w_mem_we_nxt;
  logic           r_mem_re, w_mem_re_nxt;
  logic           w_legal;
  logic           w_misaligned;

  assign w_legal = f_funct3_legal(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = f_misaligned(req_funct3[1:0], req_addr[1:0]);
`else
  // mem_ctl is byte-addressed, so any address can be issued directly.
  assign w_misaligned = 1'b0;
`endif

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    w_state_nxt         = r_state;
    w_we_nxt            = r_we;
    w_funct3_nxt        = r_funct3;
    w_to_cnt_nxt        = r_to_cnt;
    w_req_ready_nxt     = r_req_ready;
    w_resp_valid_nxt    = r_resp_valid;
    w_resp_rdata_nxt    = r_resp_rdata;
    w_resp_err_nxt      = r_resp_err;
    w_resp_err_code_nxt = r_resp_err_code;
    w_mem_addr_nxt      = r_mem_addr;
    w_mem_wdata_nxt     = r_mem_wdata;
    w_mem_wflag_nxt     = r_mem_wflag;
    w_mem_we_nxt        = r_mem_we;
    w_mem_re_nxt        = r_mem_re;

    case (r_state)
      ST_IDLE: begin
        // req_ready rises on the first edge after reset and stays up while idle.
        w_req_ready_nxt = 1'b1;
        if (r_req_ready && req_valid) begin
          w_req_ready_nxt  = 1'b0;
          w_we_nxt         = req_we;
          w_funct3_nxt     = req_funct3;
          w_resp_rdata_nxt = 32'h0000_0000;
          if (!w_legal) begin
            w_state_nxt         = ST_RESP;
            w_resp_err_nxt      = 1'b1;
            w_resp_err_code_nxt = ERR_FUNCT3;
          end else if (w_misaligned) begin
            w_state_nxt         = ST_RESP;
            w_resp_err_nxt      = 1'b1;
            w_resp_err_code_nxt = ERR_MISALIGN;
          end else begin
            w_state_nxt     = ST_ISSUE;
            w_to_cnt_nxt    = '0;
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_we ? f_store_data(req_funct3[1:0], req_wdata) : 32'h0000_0000;
            w_mem_wflag_nxt = req_we ? req_funct3 : 3'b000;
            w_mem_we_nxt    = req_we;
            w_mem_re_nxt    = !req_we;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (mem_ready) begin
          w_state_nxt         = ST_RESP;
          w_mem_we_nxt        = 1'b0;
          w_mem_re_nxt        = 1'b0;
          w_resp_valid_nxt    = 1'b1;
          w_resp_err_nxt      = 1'b0;
          w_resp_err_code_nxt = ERR_NONE;
          w_resp_rdata_nxt    = r_we ? 32'h0000_0000 : f_load_ext(r_funct3, mem_rdata);
        end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
          w_state_nxt         = ST_RESP;
          w_mem_we_nxt        = 1'b0;
          w_mem_re_nxt        = 1'b0;
          w_resp_valid_nxt    = 1'b1;
          w_resp_err_nxt      = 1'b1;
          w_resp_err_code_nxt = ERR_TIMEOUT;
          w_resp_rdata_nxt    = 32'h0000_0000;
        end else begin
          w_to_cnt_nxt = r_to_cnt + CW'(1);
        end
      end

      ST_RESP: begin
        // Accesses enter here with resp_valid already set. Rejected requests
        // enter with it clear and raise it one edge later, so every request
        // answers no earlier than one cycle after acceptance.
        if (r_resp_valid) begin
          w_state_nxt         = ST_IDLE;
          w_req_ready_nxt     = 1'b1;
          w_resp_valid_nxt    = 1'b0;
          w_resp_err_nxt      = 1'b0;
          w_resp_err_code_nxt = ERR_NONE;
          w_resp_rdata_nxt    = 32'h0000_0000;
        end else begin
          w_resp_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_req_ready_nxt  = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_re_nxt     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_we            <= 1'b0;
      r_funct3        <= 3'b000;
      r_to_cnt        <= '0;
      r_req_ready     <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= 32'h0000_0000;
      r_resp_err      <= 1'b0;
      r_resp_err_code <= 2'b00;
      r_mem_addr      <= 32'h0000_0000;
      r_mem_wdata     <= 32'h0000_0000;
      r_mem_wflag     <= 3'b000;
      r_mem_we        <= 1'b0;
      r_mem_re        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_we            <= w_we_nxt;
      r_funct3        <= w_funct3_nxt;
      r_to_cnt        <= w_to_cnt_nxt;
      r_req_ready     <= w_req_ready_nxt;
      r_resp_valid    <= w_resp_valid_nxt;
      r_resp_rdata    <= w_resp_rdata_nxt;
      r_resp_err      <= w_resp_err_nxt;
      r_resp_err_code <= w_resp_err_code_nxt;
      r_mem_addr      <= w_mem_addr_nxt;
      r_mem_wdata     <= w_mem_wdata_nxt;
      r_mem_wflag     <= w_mem_wflag_nxt;
      r_mem_we        <= w_mem_we_nxt;
      r_mem_re        <= w_mem_re_nxt;
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign resp_err_code = r_resp_err_code;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wflag     = r_mem_wflag;
  assign mem_we        = r_mem_we;
  assign mem_re        = r_mem_re;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A byte-addressed memory model
// answers strobes like mem_ctl (ready on the negedge after the strobe).
// A directed vector table covers the basic loads and stores, illegal funct3
// and misalignment. Randomized requests are compared against a byte-array
// reference model. Hand-written sequences cover reset, the timeout and a
// reset during an outstanding access.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err_code;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_wflag;
  logic        mem_we, mem_re, mem_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_err_code(resp_err_code),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wflag(mem_wflag),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory model (behaves like mem_ctl) ----------------
  bit [7:0]    bmem [bit [31:0]];
  bit          hold_ready = 1'b0;
  int          strobe_cycles = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [2:0]  obs_wflag;
  logic        obs_we, obs_re;

  function automatic logic [7:0] rdb(input bit [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      strobe_cycles = strobe_cycles + 1;
      obs_addr  = mem_addr;
      obs_wdata = mem_wdata;
      obs_wflag = mem_wflag;
      obs_we    = mem_we;
      obs_re    = mem_re;
    end
    if (!hold_ready && (mem_we || mem_re) && !mem_ready) begin
      if (mem_we) begin
        for (int i = 0; i < size_bytes(mem_wflag[1:0]); i++)
          bmem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
      end
      mem_rdata = {rdb(mem_addr + 32'd3), rdb(mem_addr + 32'd2),
                   rdb(mem_addr + 32'd1), rdb(mem_addr)};
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  bit [7:0] rmem [bit [31:0]];

  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [1:0] code,
                           output logic [31:0] rd, output bit acc);
    int     n;
    bit     legal;
    longint v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = size_bytes(f3[1:0]);
    code = 2'b00; rd = 32'h0; acc = 1'b0;
    if (!legal) code = 2'b10;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (n > 1 && (addr % n) != 0) code = 2'b01;
`endif
    else begin
      acc = 1'b1;
      if (we) begin
        for (int i = 0; i < n; i++) rmem[addr + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v + (longint'(rmem.exists(addr + 32'(i)) ? rmem[addr + 32'(i)] : 8'h00) << (8*i));
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        rd = v[31:0];
      end
    end
  endtask

  // ---------------- request driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output logic [1:0] code, output logic one_cycle);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    strobe_cycles = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'h0; err = 1'b0; code = 2'b00; one_cycle = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; rd = resp_rdata; err = resp_err; code = resp_err_code;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      one_cycle = !resp_valid && req_ready;
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  code;
    logic [31:0] rdata;
    bit          access;
    logic [31:0] mwdata;
  } vec_t;

  vec_t        tv[$];
  int          lat;
  logic [31:0] rd, e_rd;
  logic        err, one;
  logic [1:0]  code, e_code;
  bit          e_acc, seen;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wd;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Directed table
    tv.push_back('{1'b1, 3'd2, 32'h2000, 32'h12345678, 2'b00, 32'h0,        1'b1, 32'h12345678});
    tv.push_back('{1'b0, 3'd2, 32'h2000, 32'h0,        2'b00, 32'h12345678, 1'b1, 32'h0});
    tv.push_back('{1'b1, 3'd0, 32'h2004, 32'h000000F0, 2'b00, 32'h0,        1'b1, 32'h000000F0});
    tv.push_back('{1'b0, 3'd0, 32'h2004, 32'h0,        2'b00, 32'hFFFFFFF0, 1'b1, 32'h0});
    tv.push_back('{1'b0, 3'd4, 32'h2004, 32'h0,        2'b00, 32'h000000F0, 1'b1, 32'h0});
    tv.push_back('{1'b1, 3'd1, 32'h2008, 32'hABCD8001, 2'b00, 32'h0,        1'b1, 32'h00008001});
    tv.push_back('{1'b0, 3'd1, 32'h2008, 32'h0,        2'b00, 32'hFFFF8001, 1'b1, 32'h0});
    tv.push_back('{1'b0, 3'd5, 32'h2008, 32'h0,        2'b00, 32'h00008001, 1'b1, 32'h0});
    tv.push_back('{1'b0, 3'd3, 32'h2000, 32'h0,        2'b10, 32'h0,        1'b0, 32'h0});
    tv.push_back('{1'b1, 3'd4, 32'h2000, 32'h55555555, 2'b10, 32'h0,        1'b0, 32'h0});
    tv.push_back('{1'b0, 3'd6, 32'h2000, 32'h0,        2'b10, 32'h0,        1'b0, 32'h0});
    tv.push_back('{1'b1, 3'd7, 32'h2000, 32'h11111111, 2'b10, 32'h0,        1'b0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    tv.push_back('{1'b0, 3'd2, 32'h2002, 32'h0,        2'b01, 32'h0,        1'b0, 32'h0});
    tv.push_back('{1'b1, 3'd1, 32'h2009, 32'h0000BEEF, 2'b01, 32'h0,        1'b0, 32'h0});
`else
    tv.push_back('{1'b0, 3'd2, 32'h2002, 32'h0,        2'b00, 32'h00F01234, 1'b1, 32'h0});
`endif

    // Reset state
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Table-driven vectors
    foreach (tv[i]) begin
      do_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, lat, rd, err, code, one);
      check($sformatf("tv%0d_latency", i), lat, 32'd2);
      check($sformatf("tv%0d_code", i), {30'd0, code}, {30'd0, tv[i].code});
      check($sformatf("tv%0d_err", i), {31'd0, err}, {31'd0, (tv[i].code != 2'b00)});
      check($sformatf("tv%0d_rdata", i), rd, tv[i].rdata);
      check($sformatf("tv%0d_one_cycle", i), {31'd0, one}, 32'd1);
      check($sformatf("tv%0d_strobes", i), strobe_cycles, tv[i].access ? 32'd1 : 32'd0);
      if (tv[i].access) begin
        check($sformatf("tv%0d_addr", i), obs_addr, tv[i].addr);
        check($sformatf("tv%0d_dir", i), {30'd0, obs_we, obs_re}, tv[i].we ? 32'd2 : 32'd1);
        if (tv[i].we) begin
          check($sformatf("tv%0d_wdata", i), obs_wdata, tv[i].mwdata);
          check($sformatf("tv%0d_wflag", i), {29'd0, obs_wflag}, {29'd0, tv[i].f3});
        end
      end
    end

    // Randomized requests against the reference model
    for (int n = 0; n < 80; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'h3000 + 32'($urandom_range(0, 15));
      r_wd   = $urandom;
      ref_model(r_we, r_f3, r_addr, r_wd, e_code, e_rd, e_acc);
      do_req(r_we, r_f3, r_addr, r_wd, lat, rd, err, code, one);
      check($sformatf("rnd%0d_latency", n), lat, 32'd2);
      check($sformatf("rnd%0d_code", n), {30'd0, code}, {30'd0, e_code});
      check($sformatf("rnd%0d_rdata", n), rd, e_rd);
      check($sformatf("rnd%0d_strobes", n), strobe_cycles, e_acc ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_one_cycle", n), {31'd0, one}, 32'd1);
    end

    // Timeout: memory never answers
    hold_ready = 1'b1;
    do_req(1'b0, 3'd2, 32'h2000, 32'h0, lat, rd, err, code, one);
    hold_ready = 1'b0;
    check("to_strobe_cycles", strobe_cycles, TO);
    check("to_strobe_was_read", {31'd0, obs_re}, 32'd1);
    check("to_latency", lat, TO + 1);
    check("to_code", {30'd0, code}, 32'd3);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_rdata", rd, 32'h0);
    check("to_one_cycle", {31'd0, one}, 32'd1);

    // Reset while the access is outstanding
    hold_ready = 1'b1;
    @(negedge clk);
    check("rst2_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h2000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2_strobe_before", {31'd0, mem_re}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_strobe_dropped", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst2_req_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rst2_no_response", {31'd0, seen}, 32'd0);
    check("rst2_ready_again", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 3'd2, 32'h2000, 32'h0, lat, rd, err, code, one);
    check("rst2_recover_rdata", rd, 32'h12345678);
    check("rst2_recover_latency", lat, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RV32I core's memory stage and the data port of `mem_ctl`. It accepts one load or store per request, validates funct3 and alignment, and issues a single byte-addressed access using the `mem_addr`/`mem_wdata`/`mem_wflag`/`mem_we`/`mem_re`/`mem_rdata`/`mem_ready` protocol. It sign- or zero-extends load data and returns a one-cycle response with an error code. Memory stalls are bounded by a timeout counter.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 255: cycles a strobe is held without `mem_ready` before a timeout error is raised; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load or store.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data.
- `resp_err`  out  1  request failed.
- `resp_err_code`  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
- `mem_addr`  out  32  to `mem_ctl`.
- `mem_wdata`  out  32  to `mem_ctl`; right-aligned, unused upper bytes zeroed.
- `mem_wflag`  out  3  store funct3, passed through.
- `mem_we`  out  1  write strobe.
- `mem_re`  out  1  read strobe.
- `mem_rdata`  in  32  bytes addr+3..addr+0, little-endian.
- `mem_ready`  in  1  access complete.

## Operation

- States: IDLE, ISSUE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
  - Illegal funct3 goes directly to RESP with code 10. Loads accept 000/001/010/100/101; stores accept 000/001/010.
  - A misaligned request (see Configuration) goes to RESP with code 01.
  - Any other request goes to ISSUE.
- ISSUE:
  - `mem_re` or `mem_we` is held high, and the address/data/flag outputs are held stable.
  - When `mem_ready` is sampled high: go to RESP with no error. Strobes drop on that same edge.
  - For a load, capture extended data:
    - LB/LH: sign-extend `mem_rdata[7:0]` / `[15:0]`.
    - LBU/LHU: zero-extend the same fields.
    - LW: pass all 32 bits.
  - Stores return `resp_rdata`=0.
- Timeout:
  - A counter clears on entry to ISSUE and increments each edge without `mem_ready`.
  - At the edge where the count equals `TIMEOUT_CYCLES`-1 with no ready: drop the strobe and go to RESP with code 11.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- On any error, `resp_rdata`=0 and no memory strobe is ever asserted, except the timed-out one.
- `mem_ready` seen in IDLE or RESP is ignored.
- Reset values: `req_ready`=0 while in reset, then 1 once in IDLE. All other outputs are 0 and the state is IDLE.
- Reset mid-ISSUE drops the strobes immediately (asynchronous) and discards the request without a response.

## Timing

- All outputs are registered.
- Request accepted at edge E:
  - Strobe is high from E.
  - With `mem_ctl` (ready is driven on the negedge after the strobe), `mem_ready` is sampled at E+1.
  - `resp_valid` is high from E+1 to E+2.
  - `req_ready` is high again from E+2.
  - Minimum of 2 cycles per request.
- Error paths with no access: `resp_valid` from E+1.
- Timeout: the strobe is high for exactly `TIMEOUT_CYCLES` cycles, and `resp_valid` follows the edge that drops it.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `req_addr[0]`=1 return code 01 with no access.
  - LW/SW with `req_addr[1:0]`≠00 return code 01 with no access.
- `LSU_MISALIGN_TRAP_EN` undefined: all addresses are issued as-is, because `mem_ctl` is byte-addressed, and code 01 never occurs.

## Test plan

- SW 0x12345678 to 0x2000, then LW 0x2000 → `mem_we` pulse with `mem_wflag`=010; load `resp_rdata`=0x12345678, `resp_err`=0, with `resp_valid` 1 cycle after acceptance.
- SB 0x000000F0 to 0x2004, then LB and LBU 0x2004 → `mem_wdata`=0x000000F0; LB returns 0xFFFFFFF0, LBU returns 0x000000F0.
- SH 0xABCD8001 to 0x2008, then LH and LHU → `mem_wdata`=0x00008001; LH returns 0xFFFF8001, LHU returns 0x00008001.
- Load with funct3=011 and store with funct3=100 → code 10, no `mem_re`/`mem_we` ever high.
- LW 0x2002:
  - with `LSU_MISALIGN_TRAP_EN` → code 01, no strobe.
  - without it → access issued at 0x2002.
- Model holds `mem_ready` low, `TIMEOUT_CYCLES`=4 → `mem_re` high for 4 cycles, then code 11 with `resp_rdata`=0. Repeat with `rst_n` pulsed low at cycle 2 → strobe low immediately, no `resp_valid`.
